// File: rtl/wb_select_stage_pkg.sv
// Shared definitions for the write-back select stage and the load/store lane logic.
// Holds write-data source encodings, load size encodings, default widths and
// the misalignment rule used when WB_MISALIGN_DROP_EN is defined.
package wb_select_stage_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;

  // Write-data source select (memToReg); indices >= 4 are user-defined.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_PC   = 2'd2,
    SRC_UIMM = 2'd3
  } src_sel_e;

  // Load size (memSize); 2'b11 is handled as a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Half with odd offset, or word with any nonzero offset, is misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_low);
    return ((size == SZ_HALF) && addr_low[0]) || (size[1] && (addr_low != 2'd0));
  endfunction

endpackage

// File: rtl/wb_select_stage_load_extend.sv
// Load lane extraction and sign/zero extension (purely combinational).
// Ports:
//   raw_i       full memory read word
//   size_i      00 byte, 01 half, 10/11 word
//   signed_i    1 = sign-extend byte/half, 0 = zero-extend
//   addr_low_i  byte offset within the word
//   data_c_o    aligned, extended result
module wb_select_stage_load_extend
  import wb_select_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] raw_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [1:0]        addr_low_i,
  output logic [DATA_W-1:0] data_c_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane pick, then extend; word passes the full width untouched.
  always_comb begin
    byte_lane = raw_i[7:0];
    case (addr_low_i)
      2'd1:    byte_lane = raw_i[15:8];
      2'd2:    byte_lane = raw_i[23:16];
      2'd3:    byte_lane = raw_i[31:24];
      default: byte_lane = raw_i[7:0];
    endcase
    // addr_low_i[0] is deliberately ignored for halves.
    half_lane = addr_low_i[1] ? raw_i[31:16] : raw_i[15:0];
    data_c_o  = raw_i;
    case (size_i)
      SZ_BYTE: data_c_o = {{(DATA_W-8){signed_i & byte_lane[7]}}, byte_lane};
      SZ_HALF: data_c_o = {{(DATA_W-16){signed_i & half_lane[15]}}, half_lane};
      default: data_c_o = raw_i;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// Write-back stage: selects register-file write data from NUM_SRC sources,
// aligns/extends load data, and registers the result with stall/flush control.
// Optional macro WB_MISALIGN_DROP_EN: misaligned loads capture zero data with
// the write enable dropped and are not counted.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   srcData               flattened sources, source k at [k*DATA_W +: DATA_W]
//   memToReg              source select (>= NUM_SRC selects zero)
//   memSize/memSigned/addrLow  load size, extension and byte offset (source 1)
//   inRegAddr/inRegWrite/inValid  incoming destination, write request, valid
//   stall/flush           hold / kill stage contents (flush wins)
//   wbData/wbRegAddr/wbRegWrite/wbValid  registered stage outputs
//   wbCount               committed-write counter (wraps)
// Requires DATA_W >= 32, NUM_SRC >= 2 and 2**SEL_W >= NUM_SRC.
module wb_select_stage
  import wb_select_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned REG_AW  = DEF_REG_AW
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] srcData,
  input  logic [SEL_W-1:0]          memToReg,
  input  logic [1:0]                memSize,
  input  logic                      memSigned,
  input  logic [1:0]                addrLow,
  input  logic [REG_AW-1:0]         inRegAddr,
  input  logic                      inRegWrite,
  input  logic                      inValid,
  input  logic                      stall,
  input  logic                      flush,
  output logic [DATA_W-1:0]         wbData,
  output logic [REG_AW-1:0]         wbRegAddr,
  output logic                      wbRegWrite,
  output logic                      wbValid,
  output logic [31:0]               wbCount
);

  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              misalign_c;
  logic              wr_qual_c;

  logic [DATA_W-1:0] data_q,  data_d;
  logic [REG_AW-1:0] addr_q,  addr_d;
  logic              we_q,    we_d;
  logic              valid_q, valid_d;
  logic [31:0]       count_q, count_d;

  wb_select_stage_load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .raw_i      (srcData[DATA_W +: DATA_W]),
    .size_i     (memSize),
    .signed_i   (memSigned),
    .addr_low_i (addrLow),
    .data_c_o   (load_data_c)
  );

  // Source mux; out-of-range selects fall through to the zero default.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (memToReg == SEL_W'(k)) begin
        sel_data_c = (k == 1) ? load_data_c : srcData[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef WB_MISALIGN_DROP_EN
  assign misalign_c = (memToReg == SEL_W'(SRC_MEM)) && is_misaligned(memSize, addrLow);
`else
  assign misalign_c = 1'b0;
`endif

  // Writes to register 0 are never committed.
  assign wr_qual_c = inRegWrite & inValid & (inRegAddr != '0) & ~misalign_c;

  // Next-state: flush kills valid/write only, stall holds everything.
  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = we_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!stall) begin
      valid_d = inValid;
      data_d  = misalign_c ? '0 : sel_data_c;
      addr_d  = inRegAddr;
      we_d    = wr_qual_c;
      if (wr_qual_c) count_d = count_q + 32'd1;
    end
  end

  // Stage registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign wbData     = data_q;
  assign wbRegAddr  = addr_q;
  assign wbRegWrite = we_q;
  assign wbValid    = valid_q;
  assign wbCount    = count_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: vector table, directed corner sequences and
// randomized traffic against a behavioural model. Also covers a NUM_SRC=3
// instance and both settings of WB_MISALIGN_DROP_EN.
module tb_wb_select_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned AW = 5;

  logic clock = 1'b0;
  logic reset;
  logic [31:0] src [4];
  logic [NS*DW-1:0] srcData;
  logic [3*DW-1:0]  srcData3;
  logic [1:0] memToReg, memSize, addrLow;
  logic memSigned, inRegWrite, inValid, stall, flush;
  logic [AW-1:0] inRegAddr;

  logic [DW-1:0] wbData, w3Data;
  logic [AW-1:0] wbRegAddr, w3RegAddr;
  logic wbRegWrite, wbValid, w3RegWrite, w3Valid;
  logic [31:0] wbCount, w3Count;

  assign srcData  = {src[3], src[2], src[1], src[0]};
  assign srcData3 = {src[2], src[1], src[0]};

  always #5 clock = ~clock;

  wb_select_stage #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .REG_AW(AW)) dut (
    .clock(clock), .reset(reset), .srcData(srcData), .memToReg(memToReg),
    .memSize(memSize), .memSigned(memSigned), .addrLow(addrLow),
    .inRegAddr(inRegAddr), .inRegWrite(inRegWrite), .inValid(inValid),
    .stall(stall), .flush(flush), .wbData(wbData), .wbRegAddr(wbRegAddr),
    .wbRegWrite(wbRegWrite), .wbValid(wbValid), .wbCount(wbCount));

  wb_select_stage #(.DATA_W(DW), .NUM_SRC(3), .SEL_W(SW), .REG_AW(AW)) dut3 (
    .clock(clock), .reset(reset), .srcData(srcData3), .memToReg(memToReg),
    .memSize(memSize), .memSigned(memSigned), .addrLow(addrLow),
    .inRegAddr(inRegAddr), .inRegWrite(inRegWrite), .inValid(inValid),
    .stall(stall), .flush(flush), .wbData(w3Data), .wbRegAddr(w3RegAddr),
    .wbRegWrite(w3RegWrite), .wbValid(w3Valid), .wbCount(w3Count));

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the main instance.
  logic [31:0] m_data, m_count;
  logic [4:0]  m_addr;
  logic        m_we, m_valid;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] al);
    logic [31:0] lane;
    if (sz == 2'd0) begin
      lane = (w >> (8 * int'(al))) & 32'hFF;
      if (sg && lane >= 32'd128) lane = lane + 32'hFFFF_FF00;
      return lane;
    end
    if (sz == 2'd1) begin
      lane = (w >> (16 * int'(al[1]))) & 32'hFFFF;
      if (sg && lane >= 32'd32768) lane = lane + 32'hFFFF_0000;
      return lane;
    end
    return w;
  endfunction

  function automatic logic ref_mis(input logic [1:0] sel, input logic [1:0] sz, input logic [1:0] al);
`ifdef WB_MISALIGN_DROP_EN
    return (sel == 2'd1) && (((sz == 2'd1) && (al % 2 == 1)) || ((sz >= 2'd2) && (al != 2'd0)));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_value(input int nsrc);
    if (int'(memToReg) >= nsrc) return 32'h0;
    if (memToReg == 2'd1) return ref_load(src[1], memSize, memSigned, addrLow);
    return src[memToReg];
  endfunction

  task automatic model_reset();
    m_data = '0; m_addr = '0; m_we = 1'b0; m_valid = 1'b0; m_count = '0;
  endtask

  // Advance model with current inputs, then one clock edge; sample 1 ns later.
  task automatic step();
    logic mis;
    mis = ref_mis(memToReg, memSize, addrLow);
    if (flush) begin
      m_valid = 1'b0;
      m_we    = 1'b0;
    end else if (!stall) begin
      m_valid = inValid;
      m_data  = mis ? 32'h0 : ref_value(NS);
      m_addr  = inRegAddr;
      m_we    = inRegWrite && inValid && (inRegAddr != 5'd0) && !mis;
      if (m_we) m_count = m_count + 32'd1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".data"},  wbData, m_data);
    chk({nm, ".addr"},  32'(wbRegAddr), 32'(m_addr));
    chk({nm, ".we"},    32'(wbRegWrite), 32'(m_we));
    chk({nm, ".valid"}, 32'(wbValid), 32'(m_valid));
    chk({nm, ".count"}, wbCount, m_count);
  endtask

  task automatic drive(input logic f, input logic s, input logic [1:0] sel, input logic [1:0] sz,
                       input logic sg, input logic [1:0] al, input logic [4:0] ra,
                       input logic rw, input logic v);
    flush = f; stall = s; memToReg = sel; memSize = sz; memSigned = sg;
    addrLow = al; inRegAddr = ra; inRegWrite = rw; inValid = v;
  endtask

  typedef struct {
    logic f, s; logic [1:0] sel, sz; logic sg; logic [1:0] al; logic [4:0] ra; logic rw, v;
    logic [31:0] e_data; logic [4:0] e_addr; logic e_we, e_valid; logic [31:0] e_count;
  } vec_t;

  vec_t tbl [17];
  logic [31:0] exp_cnt;

  initial begin
    //          f    s    sel  sz   sg   al   ra     rw   v     data          addr   we   vld  count
    tbl[0]  = '{1'b0,1'b0,2'd0,2'd2,1'b0,2'd0,5'd5,  1'b1,1'b1, 32'h0000_1234,5'd5,  1'b1,1'b1,32'd1};
    tbl[1]  = '{1'b0,1'b0,2'd1,2'd0,1'b1,2'd3,5'd6,  1'b1,1'b1, 32'hFFFF_FF80,5'd6,  1'b1,1'b1,32'd2};
    tbl[2]  = '{1'b0,1'b0,2'd1,2'd0,1'b0,2'd3,5'd6,  1'b1,1'b1, 32'h0000_0080,5'd6,  1'b1,1'b1,32'd3};
    tbl[3]  = '{1'b0,1'b0,2'd1,2'd1,1'b1,2'd2,5'd7,  1'b1,1'b1, 32'hFFFF_80FF,5'd7,  1'b1,1'b1,32'd4};
    tbl[4]  = '{1'b0,1'b0,2'd1,2'd0,1'b1,2'd1,5'd8,  1'b1,1'b1, 32'h0000_007F,5'd8,  1'b1,1'b1,32'd5};
    tbl[5]  = '{1'b0,1'b0,2'd1,2'd1,1'b1,2'd0,5'd9,  1'b1,1'b1, 32'h0000_7F01,5'd9,  1'b1,1'b1,32'd6};
    tbl[6]  = '{1'b0,1'b0,2'd1,2'd2,1'b0,2'd0,5'd10, 1'b1,1'b1, 32'h80FF_7F01,5'd10, 1'b1,1'b1,32'd7};
    tbl[7]  = '{1'b0,1'b0,2'd1,2'd3,1'b1,2'd0,5'd11, 1'b1,1'b1, 32'h80FF_7F01,5'd11, 1'b1,1'b1,32'd8};
    tbl[8]  = '{1'b0,1'b0,2'd3,2'd2,1'b0,2'd0,5'd12, 1'b1,1'b1, 32'h1234_5000,5'd12, 1'b1,1'b1,32'd9};
    tbl[9]  = '{1'b0,1'b0,2'd0,2'd2,1'b0,2'd0,5'd0,  1'b1,1'b1, 32'h0000_1234,5'd0,  1'b0,1'b1,32'd9};
    tbl[10] = '{1'b0,1'b0,2'd2,2'd2,1'b0,2'd0,5'd13, 1'b0,1'b1, 32'h0040_0008,5'd13, 1'b0,1'b1,32'd9};
    tbl[11] = '{1'b0,1'b0,2'd0,2'd2,1'b0,2'd0,5'd7,  1'b1,1'b0, 32'h0000_1234,5'd7,  1'b0,1'b0,32'd9};
    tbl[12] = '{1'b1,1'b1,2'd2,2'd2,1'b0,2'd0,5'd14, 1'b1,1'b1, 32'h0000_1234,5'd7,  1'b0,1'b0,32'd9};
    tbl[13] = '{1'b1,1'b0,2'd2,2'd2,1'b0,2'd0,5'd14, 1'b1,1'b1, 32'h0000_1234,5'd7,  1'b0,1'b0,32'd9};
    tbl[14] = '{1'b0,1'b1,2'd2,2'd2,1'b0,2'd0,5'd14, 1'b1,1'b1, 32'h0000_1234,5'd7,  1'b0,1'b0,32'd9};
    tbl[15] = '{1'b0,1'b0,2'd2,2'd2,1'b0,2'd0,5'd14, 1'b1,1'b1, 32'h0040_0008,5'd14, 1'b1,1'b1,32'd10};
    tbl[16] = '{1'b0,1'b0,2'd1,2'd0,1'b1,2'd2,5'd15, 1'b1,1'b1, 32'hFFFF_FFFF,5'd15, 1'b1,1'b1,32'd11};

    src[0] = 32'h0000_1234; src[1] = 32'h80FF_7F01;
    src[2] = 32'h0040_0008; src[3] = 32'h1234_5000;
    drive(1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);

    // Reset state.
    reset = 1'b0;
    model_reset();
    #12;
    chk_model("reset");
    chk("reset.dut3_valid", 32'(w3Valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Vector table.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].f, tbl[i].s, tbl[i].sel, tbl[i].sz, tbl[i].sg, tbl[i].al,
            tbl[i].ra, tbl[i].rw, tbl[i].v);
      step();
      chk($sformatf("vec%0d.data", i),  wbData, tbl[i].e_data);
      chk($sformatf("vec%0d.addr", i),  32'(wbRegAddr), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d.we", i),    32'(wbRegWrite), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d.valid", i), 32'(wbValid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.count", i), wbCount, tbl[i].e_count);
    end

    // Three stalled edges hold, the fourth captures.
    drive(1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 2'd0, 5'd16, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.data", i), wbData, 32'hFFFF_FFFF);
      chk($sformatf("stall%0d.addr", i), 32'(wbRegAddr), 32'd15);
      chk($sformatf("stall%0d.count", i), wbCount, 32'd11);
    end
    stall = 1'b0;
    step();
    chk("unstall.data", wbData, 32'h0040_0008);
    chk("unstall.addr", 32'(wbRegAddr), 32'd16);
    chk("unstall.count", wbCount, 32'd12);
    chk_model("unstall");

    // NUM_SRC=3: select 3 is out of range and yields zero.
    drive(1'b0, 1'b0, 2'd3, 2'd2, 1'b0, 2'd0, 5'd17, 1'b1, 1'b1);
    step();
    chk("ns3.sel3_data", w3Data, 32'h0);
    chk("ns3.sel3_we", 32'(w3RegWrite), 32'd1);
    chk("ns4.sel3_data", wbData, 32'h1234_5000);
    memToReg = 2'd2;
    step();
    chk("ns3.sel2_data", w3Data, 32'h0040_0008);

    // Counter wrap.
    dut.count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd0, 5'd3, 1'b1, 1'b1);
    step();
    chk("wrap.count0", wbCount, 32'd0);
    step();
    chk("wrap.count1", wbCount, 32'd1);

    // Misaligned loads.
    exp_cnt = m_count;
    drive(1'b0, 1'b0, 2'd1, 2'd2, 1'b0, 2'd2, 5'd9, 1'b1, 1'b1);
    step();
`ifdef WB_MISALIGN_DROP_EN
    chk("mis_word.data", wbData, 32'h0);
    chk("mis_word.we", 32'(wbRegWrite), 32'd0);
    chk("mis_word.valid", 32'(wbValid), 32'd1);
    chk("mis_word.count", wbCount, exp_cnt);
`else
    chk("mis_word.data", wbData, 32'h80FF_7F01);
    chk("mis_word.we", 32'(wbRegWrite), 32'd1);
    chk("mis_word.count", wbCount, exp_cnt + 32'd1);
`endif
    drive(1'b0, 1'b0, 2'd1, 2'd1, 1'b1, 2'd3, 5'd9, 1'b1, 1'b1);
    step();
    chk_model("mis_half3");
    drive(1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'd3, 5'd9, 1'b1, 1'b1);
    step();
    chk_model("byte3_aligned");

    // Reset asserted mid-stall clears at once; first capture after is normal.
    drive(1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 5'd4, 1'b1, 1'b1);
    step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk_model("midreset");
    @(negedge clock);
    reset = 1'b1;
    stall = 1'b0;
    step();
    chk("postreset.data", wbData, 32'h0000_1234);
    chk("postreset.addr", 32'(wbRegAddr), 32'd4);
    chk("postreset.count", wbCount, 32'd1);
    chk_model("postreset");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
      step();
      chk_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised write-back stage for the datapath.
- Selects the register-file write data from NUM_SRC sources.
- Aligns and sign/zero-extends load data.
- Registers the result with valid/stall/flush control. Sits between the memory stage and the register-file write port; also drives the forwarding bus.

Parameters:
- DATA_W, 32, datapath width; must be at least 32.
- NUM_SRC, 4, number of write-data sources. Index 0 aluResult, 1 readData (load path), 2 nextPC, 3 upper immediate, further indices user-defined.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_SRC.
- REG_AW, 5, register address width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- srcData  in  NUM_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W].
- memToReg  in  SEL_W  source select.
- memSize  in  2  load size: 00 byte, 01 half, 10 word, 11 treated as word.
- memSigned  in  1  1 = sign-extend, 0 = zero-extend (byte/half only).
- addrLow  in  2  load byte offset.
- inRegAddr  in  REG_AW  destination register.
- inRegWrite  in  1  write request.
- inValid  in  1  input bundle valid.
- stall  in  1  hold stage contents.
- flush  in  1  kill stage contents.
- wbData  out  DATA_W  registered write data.
- wbRegAddr  out  REG_AW  registered destination.
- wbRegWrite  out  1  registered write enable (qualified).
- wbValid  out  1  stage holds a valid instruction.
- wbCount  out  32  committed-write counter.

Behaviour:
- Reset (reset=0, asynchronous): wbData=0, wbRegAddr=0, wbRegWrite=0, wbValid=0, wbCount=0.
- Latency: one cycle. Inputs sampled at the rising edge; outputs update the same edge.
- Capture rule, evaluated in priority order:
  - flush=1: wbValid<=0 and wbRegWrite<=0; wbData and wbRegAddr hold. Flush beats stall.
  - stall=1: all outputs hold.
  - Otherwise: wbValid<=inValid; wbData<=selected value; wbRegAddr<=inRegAddr; wbRegWrite<=inRegWrite & inValid & (inRegAddr!=0).
- Select:
  - memToReg < NUM_SRC picks source memToReg.
  - memToReg >= NUM_SRC yields all zeros. This is a defined value, never a hold/latch.
- Load path, applied to source 1 only:
  - byte: lane = srcData1[8*addrLow +: 8].
  - half: lane = srcData1[16*addrLow[1] +: 16]; addrLow[0] ignored.
  - word: full DATA_W, no extension.
  - byte/half extension to DATA_W: sign bit of lane if memSigned, else zeros.
- wbCount:
  - Increments by 1 on each edge where a new bundle is captured (no flush, no stall) with the qualified write enable = 1.
  - Wraps at 2^32-1 -> 0.
  - Not affected by flush except that the flushed bundle does not count.
- Flush has no effect on wbCount for bundles already captured.
- Reset asserted mid-stall clears everything immediately; after release the first capture proceeds normally.

Optional Feature:
- Macro WB_MISALIGN_DROP_EN.
- Defined:
  - A load (memToReg==1) with half and addrLow[0]=1, or word/11 and addrLow!=0, is misaligned.
  - On capture of a misaligned load: wbRegWrite<=0, wbValid<=inValid, wbData<=0.
  - The misaligned bundle does not increment wbCount.
- Undefined: no check; misaligned accesses use the lane rules above (word ignores addrLow).

Decomposition:
- Shared package holds:
  - memToReg encodings: SRC_ALU=0, SRC_MEM=1, SRC_PC=2, SRC_UIMM=3.
  - memSize encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - Default widths: DATA_W, REG_AW.
- One natural combinational sub-module, load_extend (inputs: raw data, memSize, memSigned, addrLow; output: extended data). It is reused later by the store path for its inverse.

Test Plan:
- Reset released; memToReg=0, srcData0=0x0000_1234, inRegAddr=5, inRegWrite=1, inValid=1 -> next edge wbData=0x1234, wbRegAddr=5, wbRegWrite=1, wbValid=1, wbCount=1.
- memToReg=1, srcData1=0x80FF_7F01, byte, addrLow=3, signed -> wbData=0xFFFF_FF80. Same with unsigned -> 0x0000_0080. Half, addrLow=2, signed -> 0xFFFF_80FF.
- memToReg=2, srcData2=0x0040_0008, stall=1 for 3 cycles then 0 -> outputs hold the previous values for 3 edges, update on the 4th.
- flush=1 and stall=1 together with a valid write -> wbValid=0, wbRegWrite=0, wbCount unchanged. inRegAddr=0 with inRegWrite=1 -> wbRegWrite=0, wbCount unchanged.
- NUM_SRC=3, memToReg=3 -> wbData=0. Force wbCount to 0xFFFF_FFFF then one committed write -> wbCount=0.
- With WB_MISALIGN_DROP_EN: word load, addrLow=2 -> wbRegWrite=0, wbData=0, wbValid=1, wbCount unchanged. Without the macro -> wbData=srcData1, wbRegWrite=1.
